tcdm_to_axi_master: RTL and testbench

// - Initiator-side bridge: turns a single-port TCDM-style memory request stream
//   (req/gnt/add/wen/wdata/be, r_valid/r_rdata) into single-beat AXI4 master transactions.
// - Lets a cluster-side requester reach SoC memory over the DMA/SoC AXI fabric.
// - Up to MAX_OUTSTANDING transactions are in flight at once.
// - Responses return in request order, reads and writes mixed.

---
 rtl/tcdm_to_axi_master.sv | 274 +++++++++++++++++++++++++++
 tb/tb_tcdm_to_axi_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_to_axi_master.sv
// rtl/tcdm_to_axi_master.sv - TCDM request stream to single-beat AXI4 master bridge
//
// Purpose:
//   Accepts TCDM-style memory requests (req/gnt/add/wen/wdata/be) and issues each
//   one as a single-beat AXI4 read or write. Up to MAX_OUTSTANDING transactions
//   may be in flight. Responses are returned on mem_r_valid_o/mem_r_rdata_o in
//   request order. A small order FIFO records each request's type. Only the AXI
//   response channel that matches the FIFO head is given ready.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   mem_req_i/mem_gnt_o    request handshake (grant is combinational)
//   mem_add_i, mem_wen_i   byte address, 1 = read / 0 = write
//   mem_wdata_i, mem_be_i  write data and byte enables
//   mem_r_valid_o          one-cycle response pulse for reads and writes
//   mem_r_rdata_o          read data (0 for write responses)
//   mem_r_err_o            error flag with the response (TCDM_TO_AXI_ERR_EN only)
//   axi_aw_*, axi_w_*, axi_b_*, axi_ar_*, axi_r_*   AXI4 master channels
//
// Configuration macro: TCDM_TO_AXI_ERR_EN adds mem_r_err_o (SLVERR/DECERR flag).

module tcdm_to_axi_master #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned AXI_ADDR_WIDTH  = 64,
   parameter int unsigned DATA_WIDTH      = 64,
   parameter int unsigned AXI_ID_WIDTH    = 4,
   parameter int unsigned AXI_ID          = 0,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   // memory side
   input  logic                        mem_req_i,
   output logic                        mem_gnt_o,
   input  logic [ADDR_WIDTH-1:0]       mem_add_i,
   input  logic                        mem_wen_i,
   input  logic [DATA_WIDTH-1:0]       mem_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]     mem_be_i,
   output logic                        mem_r_valid_o,
   output logic [DATA_WIDTH-1:0]       mem_r_rdata_o,
`ifdef TCDM_TO_AXI_ERR_EN
   output logic                        mem_r_err_o,
`endif
   // AW channel
   output logic                        axi_aw_valid_o,
   input  logic                        axi_aw_ready_i,
   output logic [AXI_ID_WIDTH-1:0]     axi_aw_id_o,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_o,
   output logic [7:0]                  axi_aw_len_o,
   output logic [2:0]                  axi_aw_size_o,
   output logic [1:0]                  axi_aw_burst_o,
   output logic [3:0]                  axi_aw_cache_o,
   output logic [2:0]                  axi_aw_prot_o,
   output logic [3:0]                  axi_aw_qos_o,
   output logic [3:0]                  axi_aw_region_o,
   output logic [5:0]                  axi_aw_atop_o,
   // W channel
   output logic                        axi_w_valid_o,
   input  logic                        axi_w_ready_i,
   output logic [DATA_WIDTH-1:0]       axi_w_data_o,
   output logic [DATA_WIDTH/8-1:0]     axi_w_strb_o,
   output logic                        axi_w_last_o,
   // B channel
   input  logic                        axi_b_valid_i,
   output logic                        axi_b_ready_o,
   input  logic [1:0]                  axi_b_resp_i,
   // AR channel
   output logic                        axi_ar_valid_o,
   input  logic                        axi_ar_ready_i,
   output logic [AXI_ID_WIDTH-1:0]     axi_ar_id_o,
   output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_o,
   output logic [7:0]                  axi_ar_len_o,
   output logic [2:0]                  axi_ar_size_o,
   output logic [1:0]                  axi_ar_burst_o,
   output logic [3:0]                  axi_ar_cache_o,
   output logic [2:0]                  axi_ar_prot_o,
   output logic [3:0]                  axi_ar_qos_o,
   output logic [3:0]                  axi_ar_region_o,
   // R channel
   input  logic                        axi_r_valid_i,
   output logic                        axi_r_ready_o,
   input  logic [DATA_WIDTH-1:0]       axi_r_data_i,
   input  logic [1:0]                  axi_r_resp_i
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   typedef enum logic [1:0] {S_IDLE, S_AR, S_WR} state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic                       r_aw_done;
   logic                       r_w_done;
   logic [ADDR_WIDTH-1:0]      r_add;
   logic [DATA_WIDTH-1:0]      r_wdata;
   logic [STRB_W-1:0]          r_be;
   // order FIFO: 1 = read, 0 = write; occupancy is r_count
   logic [MAX_OUTSTANDING-1:0] r_fifo_is_rd;
   logic [PTR_W-1:0]           r_wr_ptr;
   logic [PTR_W-1:0]           r_rd_ptr;
   logic [CNT_W-1:0]           r_count;
   logic                       r_rsp_valid;
   logic [DATA_WIDTH-1:0]      r_rsp_rdata;

   logic w_gnt;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_ar_hs;
   logic w_r_hs;
   logic w_b_hs;
   logic w_retire;
   logic w_head_is_rd;
   logic w_fifo_empty;
   logic w_wr_complete;

   assign w_fifo_empty = (r_count == '0);
   assign w_head_is_rd = r_fifo_is_rd[r_rd_ptr];
   assign w_gnt        = mem_req_i & (r_state == S_IDLE) & (r_count < CNT_MAX);

   assign w_aw_hs  = axi_aw_valid_o & axi_aw_ready_i;
   assign w_w_hs   = axi_w_valid_o  & axi_w_ready_i;
   assign w_ar_hs  = axi_ar_valid_o & axi_ar_ready_i;
   assign w_r_hs   = axi_r_valid_i  & axi_r_ready_o;
   assign w_b_hs   = axi_b_valid_i  & axi_b_ready_o;
   assign w_retire = w_r_hs | w_b_hs;

   // A write completes when each of AW and W has handshaken, now or earlier.
   assign w_wr_complete = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_gnt) w_state_nxt = mem_wen_i ? S_AR : S_WR;
         S_AR:    if (w_ar_hs) w_state_nxt = S_IDLE;
         S_WR:    if (w_wr_complete) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      axi_ar_valid_o = 1'b0;
      axi_aw_valid_o = 1'b0;
      axi_w_valid_o  = 1'b0;
      case (r_state)
         S_AR: axi_ar_valid_o = 1'b1;
         S_WR: begin
            axi_aw_valid_o = ~r_aw_done;
            axi_w_valid_o  = ~r_w_done;
         end
         default: ;
      endcase
   end

   // AW/W completion tracking; cleared whenever the write is not in progress.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else if (r_state == S_WR && w_state_nxt == S_WR) begin
         r_aw_done <= r_aw_done | w_aw_hs;
         r_w_done  <= r_w_done  | w_w_hs;
      end else begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end
   end

   // Request capture and order FIFO bookkeeping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_add        <= '0;
         r_wdata      <= '0;
         r_be         <= '0;
         r_fifo_is_rd <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
      end else begin
         if (w_gnt) begin
            r_add                  <= mem_add_i;
            r_wdata                <= mem_wdata_i;
            r_be                   <= mem_be_i;
            r_fifo_is_rd[r_wr_ptr] <= mem_wen_i;
            r_wr_ptr               <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_retire) begin
            r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_gnt, w_retire})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   // Only the channel matching the oldest outstanding request is accepted,
   // which keeps responses in request order across R and B.
   assign axi_r_ready_o = ~w_fifo_empty &  w_head_is_rd;
   assign axi_b_ready_o = ~w_fifo_empty & ~w_head_is_rd;

   // Response to the memory side, one cycle after the AXI handshake.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_retire;
         r_rsp_rdata <= w_r_hs ? axi_r_data_i : '0;
      end
   end

   assign mem_gnt_o     = w_gnt;
   assign mem_r_valid_o = r_rsp_valid;
   assign mem_r_rdata_o = r_rsp_rdata;

`ifdef TCDM_TO_AXI_ERR_EN
   // resp[1] set means SLVERR (2'b10) or DECERR (2'b11).
   logic r_rsp_err;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rsp_err <= 1'b0;
      end else begin
         r_rsp_err <= (w_r_hs & axi_r_resp_i[1]) | (w_b_hs & axi_b_resp_i[1]);
      end
   end
   assign mem_r_err_o = r_rsp_err;
`else
   logic w_unused_resp;
   assign w_unused_resp = ^{axi_r_resp_i, axi_b_resp_i};
`endif

   // Fixed single-beat AXI attributes.
   assign axi_aw_id_o     = AXI_ID_WIDTH'(AXI_ID);
   assign axi_aw_addr_o   = AXI_ADDR_WIDTH'(r_add);
   assign axi_aw_len_o    = 8'd0;
   assign axi_aw_size_o   = 3'($clog2(STRB_W));
   assign axi_aw_burst_o  = 2'b01;
   assign axi_aw_cache_o  = 4'd0;
   assign axi_aw_prot_o   = 3'd0;
   assign axi_aw_qos_o    = 4'd0;
   assign axi_aw_region_o = 4'd0;
   assign axi_aw_atop_o   = 6'd0;

   assign axi_w_data_o    = r_wdata;
   assign axi_w_strb_o    = r_be;
   assign axi_w_last_o    = 1'b1;

   assign axi_ar_id_o     = AXI_ID_WIDTH'(AXI_ID);
   assign axi_ar_addr_o   = AXI_ADDR_WIDTH'(r_add);
   assign axi_ar_len_o    = 8'd0;
   assign axi_ar_size_o   = 3'($clog2(STRB_W));
   assign axi_ar_burst_o  = 2'b01;
   assign axi_ar_cache_o  = 4'd0;
   assign axi_ar_prot_o   = 3'd0;
   assign axi_ar_qos_o    = 4'd0;
   assign axi_ar_region_o = 4'd0;

endmodule

// File: tb/tb_tcdm_to_axi_master.sv
// tb/tb_tcdm_to_axi_master.sv - self-checking bench for tcdm_to_axi_master

module tb_tcdm_to_axi_master;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mem_req_i, mem_gnt_o, mem_wen_i;
   logic [31:0] mem_add_i;
   logic [63:0] mem_wdata_i;
   logic [7:0]  mem_be_i;
   logic        mem_r_valid_o;
   logic [63:0] mem_r_rdata_o;
`ifdef TCDM_TO_AXI_ERR_EN
   logic        mem_r_err_o;
`endif
   logic        axi_aw_valid_o, axi_aw_ready_i;
   logic [3:0]  axi_aw_id_o, axi_aw_cache_o, axi_aw_qos_o, axi_aw_region_o;
   logic [63:0] axi_aw_addr_o;
   logic [7:0]  axi_aw_len_o;
   logic [2:0]  axi_aw_size_o, axi_aw_prot_o;
   logic [1:0]  axi_aw_burst_o;
   logic [5:0]  axi_aw_atop_o;
   logic        axi_w_valid_o, axi_w_ready_i, axi_w_last_o;
   logic [63:0] axi_w_data_o;
   logic [7:0]  axi_w_strb_o;
   logic        axi_b_valid_i, axi_b_ready_o;
   logic [1:0]  axi_b_resp_i;
   logic        axi_ar_valid_o, axi_ar_ready_i;
   logic [3:0]  axi_ar_id_o, axi_ar_cache_o, axi_ar_qos_o, axi_ar_region_o;
   logic [63:0] axi_ar_addr_o;
   logic [7:0]  axi_ar_len_o;
   logic [2:0]  axi_ar_size_o, axi_ar_prot_o;
   logic [1:0]  axi_ar_burst_o;
   logic        axi_r_valid_i, axi_r_ready_o;
   logic [63:0] axi_r_data_i;
   logic [1:0]  axi_r_resp_i;

   tcdm_to_axi_master dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_add_i(mem_add_i),
      .mem_wen_i(mem_wen_i), .mem_wdata_i(mem_wdata_i), .mem_be_i(mem_be_i),
      .mem_r_valid_o(mem_r_valid_o), .mem_r_rdata_o(mem_r_rdata_o),
`ifdef TCDM_TO_AXI_ERR_EN
      .mem_r_err_o(mem_r_err_o),
`endif
      .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
      .axi_aw_id_o(axi_aw_id_o), .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_len_o(axi_aw_len_o),
      .axi_aw_size_o(axi_aw_size_o), .axi_aw_burst_o(axi_aw_burst_o),
      .axi_aw_cache_o(axi_aw_cache_o), .axi_aw_prot_o(axi_aw_prot_o),
      .axi_aw_qos_o(axi_aw_qos_o), .axi_aw_region_o(axi_aw_region_o),
      .axi_aw_atop_o(axi_aw_atop_o),
      .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
      .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
      .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o), .axi_b_resp_i(axi_b_resp_i),
      .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
      .axi_ar_id_o(axi_ar_id_o), .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_len_o(axi_ar_len_o),
      .axi_ar_size_o(axi_ar_size_o), .axi_ar_burst_o(axi_ar_burst_o),
      .axi_ar_cache_o(axi_ar_cache_o), .axi_ar_prot_o(axi_ar_prot_o),
      .axi_ar_qos_o(axi_ar_qos_o), .axi_ar_region_o(axi_ar_region_o),
      .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
      .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        wen;
      logic [31:0] add;
      logic [7:0]  be;
      logic [63:0] wdata;
      logic [63:0] slv_rdata;
      logic [1:0]  resp;
      logic [63:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [6];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic slave_idle();
      axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0; axi_ar_ready_i = 1'b0;
      axi_b_valid_i  = 1'b0; axi_b_resp_i  = 2'b00;
      axi_r_valid_i  = 1'b0; axi_r_data_i  = '0; axi_r_resp_i = 2'b00;
   endtask

   // Present a request and hold it until granted (bounded), then drop it.
   task automatic issue(input logic wen, input logic [31:0] add, input logic [7:0] be,
                        input logic [63:0] wd);
      bit got = 1'b0;
      mem_req_i = 1'b1; mem_wen_i = wen; mem_add_i = add; mem_be_i = be; mem_wdata_i = wd;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (mem_gnt_o) begin
            got = 1'b1;
            break;
         end
         step();
      end
      chk("issue_gnt_wait", 64'(got), 64'd1);
      step();
      mem_req_i = 1'b0;
   endtask

   // One transaction against a zero-wait slave: grant c0, A c1, R/B c2, response c3.
   task automatic do_txn(input vec_t v, input int idx);
      mem_req_i = 1'b1; mem_wen_i = v.wen; mem_add_i = v.add; mem_be_i = v.be;
      mem_wdata_i = v.wdata;
      #1 chk($sformatf("v%0d_gnt", idx), 64'(mem_gnt_o), 64'd1);
      step();
      mem_req_i = 1'b0;
      if (v.wen) begin
         axi_ar_ready_i = 1'b1;
         chk($sformatf("v%0d_ar_valid", idx), 64'(axi_ar_valid_o), 64'd1);
         chk($sformatf("v%0d_ar_addr", idx), axi_ar_addr_o, {32'h0, v.add});
         chk($sformatf("v%0d_ar_len", idx), 64'(axi_ar_len_o), 64'd0);
         chk($sformatf("v%0d_ar_size", idx), 64'(axi_ar_size_o), 64'd3);
         chk($sformatf("v%0d_ar_burst", idx), 64'(axi_ar_burst_o), 64'd1);
         chk($sformatf("v%0d_ar_id", idx), 64'(axi_ar_id_o), 64'd0);
         chk($sformatf("v%0d_aw_quiet", idx), 64'(axi_aw_valid_o), 64'd0);
         step();
         axi_ar_ready_i = 1'b0;
         chk($sformatf("v%0d_ar_drop", idx), 64'(axi_ar_valid_o), 64'd0);
         axi_r_valid_i = 1'b1; axi_r_data_i = v.slv_rdata; axi_r_resp_i = v.resp;
         #1 chk($sformatf("v%0d_r_ready", idx), 64'(axi_r_ready_o), 64'd1);
         chk($sformatf("v%0d_b_ready", idx), 64'(axi_b_ready_o), 64'd0);
         step();
         axi_r_valid_i = 1'b0;
      end else begin
         axi_aw_ready_i = 1'b1; axi_w_ready_i = 1'b1;
         chk($sformatf("v%0d_aw_valid", idx), 64'(axi_aw_valid_o), 64'd1);
         chk($sformatf("v%0d_w_valid", idx), 64'(axi_w_valid_o), 64'd1);
         chk($sformatf("v%0d_aw_addr", idx), axi_aw_addr_o, {32'h0, v.add});
         chk($sformatf("v%0d_aw_size", idx), 64'(axi_aw_size_o), 64'd3);
         chk($sformatf("v%0d_w_strb", idx), 64'(axi_w_strb_o), 64'(v.be));
         chk($sformatf("v%0d_w_data", idx), axi_w_data_o, v.wdata);
         chk($sformatf("v%0d_w_last", idx), 64'(axi_w_last_o), 64'd1);
         chk($sformatf("v%0d_ar_quiet", idx), 64'(axi_ar_valid_o), 64'd0);
         step();
         axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0;
         chk($sformatf("v%0d_aw_drop", idx), 64'(axi_aw_valid_o | axi_w_valid_o), 64'd0);
         axi_b_valid_i = 1'b1; axi_b_resp_i = v.resp;
         #1 chk($sformatf("v%0d_b_ready", idx), 64'(axi_b_ready_o), 64'd1);
         chk($sformatf("v%0d_r_ready", idx), 64'(axi_r_ready_o), 64'd0);
         step();
         axi_b_valid_i = 1'b0;
      end
      chk($sformatf("v%0d_rsp_valid", idx), 64'(mem_r_valid_o), 64'd1);
      chk($sformatf("v%0d_rsp_rdata", idx), mem_r_rdata_o, v.exp_rdata);
`ifdef TCDM_TO_AXI_ERR_EN
      chk($sformatf("v%0d_rsp_err", idx), 64'(mem_r_err_o), 64'(v.exp_err));
`endif
      step();
      chk($sformatf("v%0d_rsp_pulse_end", idx), 64'(mem_r_valid_o), 64'd0);
   endtask

   initial begin
      int ngrant;
      int npulse;

      vecs[0] = '{1'b1, 32'h0000_0100, 8'h00, 64'h0, 64'hDEADBEEF_CAFEF00D, 2'b00,
                  64'hDEADBEEF_CAFEF00D, 1'b0};
      vecs[1] = '{1'b0, 32'h0000_0040, 8'h0F, 64'h11223344_55667788, 64'h0, 2'b00,
                  64'h0, 1'b0};
      vecs[2] = '{1'b1, 32'hFFFF_FFF8, 8'h00, 64'h0, 64'h01234567_89ABCDEF, 2'b10,
                  64'h01234567_89ABCDEF, 1'b1};
      vecs[3] = '{1'b1, 32'h0000_0008, 8'h00, 64'h0, 64'hA5A5A5A5_5A5A5A5A, 2'b00,
                  64'hA5A5A5A5_5A5A5A5A, 1'b0};
      vecs[4] = '{1'b0, 32'h0000_0000, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 2'b11,
                  64'h0, 1'b1};
      vecs[5] = '{1'b0, 32'h0000_1238, 8'h80, 64'h80000000_00000001, 64'h0, 2'b01,
                  64'h0, 1'b0};

      rst_i = 1'b1;
      mem_req_i = 1'b0; mem_wen_i = 1'b0; mem_add_i = '0; mem_be_i = '0; mem_wdata_i = '0;
      slave_idle();
      step();
      step();
      chk("rst_gnt", 64'(mem_gnt_o), 64'd0);
      chk("rst_valids", 64'({axi_aw_valid_o, axi_w_valid_o, axi_ar_valid_o}), 64'd0);
      chk("rst_readies", 64'({axi_r_ready_o, axi_b_ready_o}), 64'd0);
      chk("rst_rsp_valid", 64'(mem_r_valid_o), 64'd0);
      chk("rst_rsp_rdata", mem_r_rdata_o, 64'd0);
`ifdef TCDM_TO_AXI_ERR_EN
      chk("rst_err", 64'(mem_r_err_o), 64'd0);
`endif
      rst_i = 1'b0;
      step();

      // Table of single transactions against a zero-wait slave.
      for (int i = 0; i < 6; i++) do_txn(vecs[i], i);

      // Write where the slave takes W two cycles before AW.
      mem_req_i = 1'b1; mem_wen_i = 1'b0; mem_add_i = 32'h40; mem_be_i = 8'h0F;
      mem_wdata_i = 64'h11223344_55667788;
      #1 chk("wf_gnt", 64'(mem_gnt_o), 64'd1);
      step();
      mem_req_i = 1'b0;
      axi_w_ready_i = 1'b1;
      chk("wf_c1_valids", 64'({axi_aw_valid_o, axi_w_valid_o}), 64'b11);
      step();
      axi_w_ready_i = 1'b0;
      chk("wf_c2_valids", 64'({axi_aw_valid_o, axi_w_valid_o}), 64'b10);
      mem_req_i = 1'b1; mem_wen_i = 1'b1;
      #1 chk("wf_busy_gnt", 64'(mem_gnt_o), 64'd0);
      mem_req_i = 1'b0;
      step();
      axi_aw_ready_i = 1'b1;
      chk("wf_c3_valids", 64'({axi_aw_valid_o, axi_w_valid_o}), 64'b10);
      chk("wf_w_strb", 64'(axi_w_strb_o), 64'h0F);
      step();
      axi_aw_ready_i = 1'b0;
      chk("wf_c4_valids", 64'({axi_aw_valid_o, axi_w_valid_o}), 64'b00);
      mem_req_i = 1'b1;
      #1 chk("wf_idle_gnt", 64'(mem_gnt_o), 64'd1);
      mem_req_i = 1'b0;
      axi_b_valid_i = 1'b1; axi_b_resp_i = 2'b00;
      #1 chk("wf_b_ready", 64'(axi_b_ready_o), 64'd1);
      step();
      axi_b_valid_i = 1'b0;
      chk("wf_rsp_valid", 64'(mem_r_valid_o), 64'd1);
      chk("wf_rsp_rdata", mem_r_rdata_o, 64'd0);
      step();

      // Outstanding limit: R stalled, reads requested back to back.
      axi_ar_ready_i = 1'b1;
      mem_req_i = 1'b1; mem_wen_i = 1'b1; mem_add_i = 32'h200;
      ngrant = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (mem_gnt_o) ngrant++;
         step();
      end
      chk("bp_grants", 64'(ngrant), 64'd4);
      axi_r_valid_i = 1'b1; axi_r_data_i = 64'h5151;
      #1 chk("bp_full_gnt", 64'(mem_gnt_o), 64'd0);
      chk("bp_r_ready", 64'(axi_r_ready_o), 64'd1);
      step();
      axi_r_valid_i = 1'b0;
      #1 chk("bp_regrant", 64'(mem_gnt_o), 64'd1);
      chk("bp_rsp_valid", 64'(mem_r_valid_o), 64'd1);
      chk("bp_rsp_rdata", mem_r_rdata_o, 64'h5151);
      step();
      mem_req_i = 1'b0;
      axi_r_valid_i = 1'b1; axi_r_data_i = 64'h77;
      npulse = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (mem_r_valid_o) npulse++;
      end
      slave_idle();
      chk("bp_drain_pulses", 64'(npulse), 64'd4);
      chk("bp_drained", 64'(axi_r_ready_o), 64'd0);
      step();

      // Ordering W1, R1, W2 with R1 offered before B(W1).
      axi_aw_ready_i = 1'b1; axi_w_ready_i = 1'b1; axi_ar_ready_i = 1'b1;
      issue(1'b0, 32'h300, 8'hFF, 64'h1);
      issue(1'b1, 32'h310, 8'h00, 64'h0);
      issue(1'b0, 32'h320, 8'hFF, 64'h2);
      step();
      step();
      slave_idle();
      axi_r_valid_i = 1'b1; axi_r_data_i = 64'hA1A1;
      #1 chk("ord_r_blocked", 64'(axi_r_ready_o), 64'd0);
      chk("ord_b_head", 64'(axi_b_ready_o), 64'd1);
      step();
      chk("ord_r_still_blocked", 64'(axi_r_ready_o), 64'd0);
      axi_b_valid_i = 1'b1;
      step();
      axi_b_valid_i = 1'b0;
      chk("ord_w1_valid", 64'(mem_r_valid_o), 64'd1);
      chk("ord_w1_rdata", mem_r_rdata_o, 64'd0);
      #1 chk("ord_r_now_ready", 64'(axi_r_ready_o), 64'd1);
      step();
      axi_r_valid_i = 1'b0;
      chk("ord_r1_valid", 64'(mem_r_valid_o), 64'd1);
      chk("ord_r1_rdata", mem_r_rdata_o, 64'hA1A1);
      axi_b_valid_i = 1'b1;
      #1 chk("ord_b2_ready", 64'(axi_b_ready_o), 64'd1);
      step();
      axi_b_valid_i = 1'b0;
      chk("ord_w2_valid", 64'(mem_r_valid_o), 64'd1);
      chk("ord_w2_rdata", mem_r_rdata_o, 64'd0);
      step();
      chk("ord_done", 64'({mem_r_valid_o, axi_r_ready_o, axi_b_ready_o}), 64'd0);

      // Reset with two reads in flight.
      axi_ar_ready_i = 1'b1;
      issue(1'b1, 32'h400, 8'h00, 64'h0);
      issue(1'b1, 32'h408, 8'h00, 64'h0);
      step();
      chk("mid_inflight", 64'(axi_r_ready_o), 64'd1);
      rst_i = 1'b1;
      axi_r_valid_i = 1'b1; axi_r_data_i = 64'h99;
      #1 chk("mid_rst_readies", 64'({axi_r_ready_o, axi_b_ready_o}), 64'd0);
      chk("mid_rst_valids", 64'({axi_aw_valid_o, axi_w_valid_o, axi_ar_valid_o}), 64'd0);
      step();
      chk("mid_rst_rsp", 64'(mem_r_valid_o), 64'd0);
      chk("mid_rst_rdata", mem_r_rdata_o, 64'd0);
      chk("mid_rst_gnt", 64'(mem_gnt_o), 64'd0);
      rst_i = 1'b0;
      slave_idle();
      step();
      chk("mid_post_rst_r_ready", 64'(axi_r_ready_o), 64'd0);
      do_txn(vecs[3], 13);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
